// File: rtl/bp_resolve_tracker.sv
// In-flight branch prediction FIFO resolved at MEM; training/redirect outputs registered 1 cycle after resolve.
// Backpressure: full stalls IF pushes; pushes while full or during a mispredict are dropped.
module bp_resolve_tracker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [31:0]       push_pc,
    input  logic              push_take,
    input  logic [2:0]        push_lgp,
    input  logic [31:0]       push_target,
    output logic              full,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic [31:0]       resolve_target,
    output logic              update_history,
    output logic              br_result,
    output logic [31:0]       mem_pc,
    output logic [31:0]       target_addr_in,
    output logic              old_l,
    output logic              old_g,
    output logic              old_p,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic              err_underflow,
    output logic [CNT_W-1:0]  n_resolved,
    output logic [CNT_W-1:0]  n_mispred
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic          take_mem [DEPTH];
    logic [2:0]    lgp_mem  [DEPTH];
    logic [31:0]   tgt_mem  [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic          pop, mis, push_ok;
    logic [31:0]   e_pc, e_tgt, fix_pc;
    logic          e_take;
    logic [2:0]    e_lgp;

    assign full    = (count == CW'(DEPTH));
    assign pop     = resolve_valid && (count != '0);
    assign e_pc    = pc_mem[rd_ptr];
    assign e_take  = take_mem[rd_ptr];
    assign e_lgp   = lgp_mem[rd_ptr];
    assign e_tgt   = tgt_mem[rd_ptr];
    assign mis     = pop && ((resolve_taken != e_take) ||
                             (resolve_taken && (resolve_target != e_tgt)));
    // Younger entries are wrong-path once the oldest mispredicts, so a same-cycle push is too.
    assign push_ok = push && !full && !mis;
    assign fix_pc  = resolve_taken ? resolve_target : e_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_ptr]   <= push_pc;
            take_mem[wr_ptr] <= push_take;
            lgp_mem[wr_ptr]  <= push_lgp;
            tgt_mem[wr_ptr]  <= push_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mis) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            update_history <= 1'b0;
            br_result      <= 1'b0;
            mem_pc         <= '0;
            target_addr_in <= '0;
            old_l          <= 1'b0;
            old_g          <= 1'b0;
            old_p          <= 1'b0;
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            err_underflow  <= 1'b0;
            n_resolved     <= '0;
            n_mispred      <= '0;
        end else begin
            update_history <= pop;
            mispredict     <= mis;
            if (pop) begin
                br_result               <= resolve_taken;
                mem_pc                  <= e_pc;
                target_addr_in          <= resolve_target;
                {old_l, old_g, old_p}   <= e_lgp;
                if (n_resolved != '1) n_resolved <= n_resolved + CNT_W'(1);
            end
            if (mis) begin
                redirect_pc <= fix_pc;
                if (n_mispred != '1) n_mispred <= n_mispred + CNT_W'(1);
            end
            if (resolve_valid && (count == '0)) err_underflow <= 1'b1;
        end
    end
endmodule
